// File: rtl/operand_recover.sv
// Recovers operands a, b, c, d from a tuple of precomputed results.
// a, b come from sum/diff; a%b and a*b run as BW-cycle iterative units.
module operand_recover #(
  parameter int unsigned BW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [BW:0]   sum,
  input  logic [BW:0]   diff,
  input  logic [BW-1:0] s3,
  input  logic [BW-1:0] s4,
  input  logic [BW-1:0] s6,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [BW-1:0] a,
  output logic [BW-1:0] b,
  output logic [BW-1:0] c,
  output logic [BW-1:0] d,
  output logic          err_parity,
  output logic          err_divzero,
  output logic          err_s6
);

  localparam int unsigned CntW = (BW > 1) ? $clog2(BW) : 1;

  typedef enum logic [2:0] {StIdle, StLoad, StIter, StFin, StOut} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [BW:0]     sum_q, sum_d, diff_q, diff_d;
  logic [BW-1:0]   s3_q, s3_d, s4_q, s4_d, s6_q, s6_d;
  logic [BW-1:0]   a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic            ep_q, ep_d, ed_q, ed_d, es_q, es_d;
  logic [BW-1:0]   rem_q, rem_d, div_q, div_d;
  logic [BW-1:0]   acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d;

  logic signed [BW+1:0] sum_x, diff_x, a_x, b_x;
  logic [BW:0]          rem_sh;
  logic [BW-1:0]        r_fin, s6_chk;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      sum_q    <= '0;
      diff_q   <= '0;
      s3_q     <= '0;
      s4_q     <= '0;
      s6_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      d_q      <= '0;
      ep_q     <= 1'b0;
      ed_q     <= 1'b0;
      es_q     <= 1'b0;
      rem_q    <= '0;
      div_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      diff_q   <= diff_d;
      s3_q     <= s3_d;
      s4_q     <= s4_d;
      s6_q     <= s6_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      d_q      <= d_d;
      ep_q     <= ep_d;
      ed_q     <= ed_d;
      es_q     <= es_d;
      rem_q    <= rem_d;
      div_q    <= div_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (in_valid) state_d = StLoad;
      StLoad:  state_d = StIter;
      StIter:  if (cnt_q == CntW'(BW - 1)) state_d = StFin;
      StFin:   state_d = StOut;
      StOut:   if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Handshake outputs
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StOut);
  end

  // Datapath
  always_comb begin
    sum_d    = sum_q;
    diff_d   = diff_q;
    s3_d     = s3_q;
    s4_d     = s4_q;
    s6_d     = s6_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    d_d      = d_q;
    ep_d     = ep_q;
    ed_d     = ed_q;
    es_d     = es_q;
    rem_d    = rem_q;
    div_d    = div_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;

    sum_x  = signed'({1'b0, sum_q});
    diff_x = signed'({diff_q[BW], diff_q});
    a_x    = (sum_x + diff_x) >>> 1;
    b_x    = (sum_x - diff_x) >>> 1;
    rem_sh = {rem_q, div_q[BW-1]};
    r_fin  = ed_q ? '0 : rem_q;
    s6_chk = s4_q + a_q - b_q;

    case (state_q)
      StIdle: begin
        if (in_valid) begin
          sum_d  = sum;
          diff_d = diff;
          s3_d   = s3;
          s4_d   = s4;
          s6_d   = s6;
          cnt_d  = '0;
        end
      end
      StLoad: begin
        a_d      = a_x[BW-1:0];
        b_d      = b_x[BW-1:0];
        ep_d     = sum_q[0] ^ diff_q[0];
        ed_d     = (b_x[BW-1:0] == '0);
        rem_d    = '0;
        div_d    = a_x[BW-1:0];
        acc_d    = '0;
        mcand_d  = a_x[BW-1:0];
        mplier_d = b_x[BW-1:0];
        cnt_d    = '0;
      end
      StIter: begin
        // Restoring division step; the remainder always stays below b
        if (rem_sh >= {1'b0, b_q}) rem_d = BW'(rem_sh - {1'b0, b_q});
        else                       rem_d = rem_sh[BW-1:0];
        div_d    = div_q << 1;
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = (cnt_q == CntW'(BW - 1)) ? '0 : cnt_q + 1'b1;
      end
      StFin: begin
        d_d  = s3_q - r_fin;
        c_d  = s4_q - (s3_q - r_fin) - acc_q;
        es_d = (s6_q != s6_chk);
      end
      default: ;
    endcase
  end

  assign a           = a_q;
  assign b           = b_q;
  assign c           = c_q;
  assign d           = d_q;
  assign err_parity  = ep_q;
  assign err_divzero = ed_q;
  assign err_s6      = es_q;

endmodule
